// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg : shared state encoding, 640x480@60 defaults, timing helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1024;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int f_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int f_sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int f_sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_ctrl_axis_counter.sv
// ----------------------------------------------------------------------------
// axis_counter : wrap counter with increment-enable, terminal count and
//                active/sync window decode of the next count value
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_next,
  output logic             o_tc,
  output logic             o_next_active,
  output logic             o_next_sync
);

  localparam logic [CNT_W-1:0] c_LAST       = CNT_W'(TOTAL - 1);
  // One extra bit so window bounds equal to 1024 still compare correctly
  localparam logic [CNT_W:0]   c_ACTIVE     = (CNT_W + 1)'(ACTIVE);
  localparam logic [CNT_W:0]   c_SYNC_START = (CNT_W + 1)'(SYNC_START);
  localparam logic [CNT_W:0]   c_SYNC_END   = (CNT_W + 1)'(SYNC_END);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic [CNT_W:0]   w_next_ext;

  assign o_tc = (r_count == c_LAST);

  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_inc) begin
      w_next = o_tc ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign w_next_ext    = {1'b0, w_next};
  assign o_next_active = (w_next_ext < c_ACTIVE);
  assign o_next_sync   = (w_next_ext >= c_SYNC_START) && (w_next_ext < c_SYNC_END);
  assign o_next        = w_next;
  assign o_count       = r_count;

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl : frame-gated VGA raster sequencer with registered outputs.
// Optional macro VGA_TIMING_PREFETCH_EN adds o_pix_req. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_enable,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_line_start,
  output logic             o_frame_start,
`ifdef VGA_TIMING_PREFETCH_EN
  output logic             o_pix_req,
`endif
  output logic             o_busy
);

  localparam int H_TOTAL = f_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = f_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed 1024");
  end

  state_t           r_state;
  state_t           w_nstate;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic             r_line_start;
  logic             r_frame_start;
  logic             r_busy;

  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_tc;
  logic             w_v_tc;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_last;
  logic             w_scan_next;
  logic             w_inc;

  assign w_last      = w_h_tc && w_v_tc;
  assign w_scan_next = (w_nstate != ST_IDLE);
  assign w_inc       = (r_state != ST_IDLE);

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:      if (i_enable) w_nstate = ST_RUN;
      ST_RUN:       if (!i_enable) w_nstate = ST_STOP_PEND;
      ST_STOP_PEND: begin
        if (i_enable) w_nstate = ST_RUN;
        else if (w_last) w_nstate = ST_IDLE;
      end
      default:      w_nstate = ST_IDLE;
    endcase
  end

  // Counters are forced to zero whenever the scan is about to stop or stay idle
  axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (f_sync_start(H_ACTIVE, H_FP)),
    .SYNC_END   (f_sync_end(H_ACTIVE, H_FP, H_SYNC))
  ) u_h_cnt (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_clr         (!w_scan_next),
    .i_inc         (w_inc),
    .o_count       (w_col),
    .o_next        (w_h_next),
    .o_tc          (w_h_tc),
    .o_next_active (w_h_act),
    .o_next_sync   (w_h_sync)
  );

  axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (f_sync_start(V_ACTIVE, V_FP)),
    .SYNC_END   (f_sync_end(V_ACTIVE, V_FP, V_SYNC))
  ) u_v_cnt (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_clr         (!w_scan_next),
    .i_inc         (w_inc && w_h_tc),
    .o_count       (w_row),
    .o_next        (w_v_next),
    .o_tc          (w_v_tc),
    .o_next_active (w_v_act),
    .o_next_sync   (w_v_sync)
  );

  // Decode from next-state counts so flags land in the same cycle as col/row
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_hsync       <= (w_scan_next && w_h_sync) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_scan_next && w_v_sync) ? SYNC_POL : ~SYNC_POL;
      r_active      <= w_scan_next && w_h_act && w_v_act;
      r_line_start  <= w_scan_next && (w_h_next == '0);
      r_frame_start <= w_scan_next && (w_h_next == '0) && (w_v_next == '0);
      r_busy        <= w_scan_next;
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   c_H_ACT  = (CNT_W + 1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   c_V_ACT  = (CNT_W + 1)'(V_ACTIVE);

  logic             r_pix_req;
  logic [CNT_W-1:0] w_h_succ;
  logic [CNT_W-1:0] w_v_succ;
  logic             w_h_nlast;
  logic             w_v_nlast;
  logic             w_succ_act;
  logic             w_stop_after;

  // Position one pixel beyond the one being loaded this edge
  assign w_h_nlast    = (w_h_next == c_H_LAST);
  assign w_v_nlast    = (w_v_next == c_V_LAST);
  assign w_h_succ     = w_h_nlast ? '0 : w_h_next + 1'b1;
  assign w_v_succ     = w_h_nlast ? (w_v_nlast ? '0 : w_v_next + 1'b1) : w_v_next;
  assign w_succ_act   = ({1'b0, w_h_succ} < c_H_ACT) && ({1'b0, w_v_succ} < c_V_ACT);
  assign w_stop_after = (w_nstate == ST_STOP_PEND) && w_h_nlast && w_v_nlast;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix_req <= 1'b0;
    end else begin
      r_pix_req <= w_scan_next && w_succ_act && !w_stop_after;
    end
  end

  assign o_pix_req = r_pix_req;
`endif

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_active      = r_active;
  assign o_col         = w_col;
  assign o_row         = w_row;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl : directed self-checking bench on a reduced 32x19 raster
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_ctrl;

  // Reduced raster: H 16+4+8+4 = 32, V 12+2+2+3 = 19, frame = 608 cycles
  localparam int H_ACT = 16;
  localparam int H_TOT = 32;
  localparam int V_ACT = 12;
  localparam int V_TOT = 19;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b0;
  logic       o_hsync, o_vsync, o_active, o_line_start, o_frame_start, o_busy;
  logic [9:0] o_col, o_row;
`ifdef VGA_TIMING_PREFETCH_EN
  logic       o_pix_req;
`endif

  int n_checks = 0;
  int n_err    = 0;

  vga_timing_ctrl #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b0)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_active      (o_active),
    .o_col         (o_col),
    .o_row         (o_row),
    .o_line_start  (o_line_start),
    .o_frame_start (o_frame_start),
`ifdef VGA_TIMING_PREFETCH_EN
    .o_pix_req     (o_pix_req),
`endif
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string p, input int col, input int row, input int hs,
                         input int vs, input int act, input int ls, input int fs, input int busy);
    chk({p, ".col"},   int'(o_col), col);
    chk({p, ".row"},   int'(o_row), row);
    chk({p, ".hsync"}, int'(o_hsync), hs);
    chk({p, ".vsync"}, int'(o_vsync), vs);
    chk({p, ".active"}, int'(o_active), act);
    chk({p, ".line_start"}, int'(o_line_start), ls);
    chk({p, ".frame_start"}, int'(o_frame_start), fs);
    chk({p, ".busy"},  int'(o_busy), busy);
  endtask

  task automatic wait_pos(input string tag, input int col, input int row);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(int'(o_col) == col && int'(o_row) == row) && k < 2000);
    chk({tag, ".reached"}, int'(k < 2000), 1);
  endtask

  int k, ec, er, pc, pr, fsc, bz, seq_bad;
  int hs_cnt, hs_first, hs_last, hs_bad, vs_cnt, vs_bad, act_cnt, act_bad, ls_cnt, ls_bad;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 1, 1, 0, 0, 0, 0);
    i_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("idle_hold", 0, 0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);

    // Start: one-edge latency into frame 0
    i_enable = 1'b1;
    @(negedge clk);
    chk_out("start", 0, 0, 1, 1, 1, 1, 1, 1);

    // One full frame of statistics, ending at the next frame_start
    k = 0; ec = 0; er = 0; seq_bad = 0;
    hs_cnt = 0; hs_first = -1; hs_last = -1; hs_bad = 0; vs_cnt = 0; vs_bad = 0;
    act_cnt = 0; act_bad = 0; ls_cnt = 0; ls_bad = 0;
    do begin
      if (!o_hsync) begin
        hs_cnt++;
        if (o_col < 20 || o_col > 27) hs_bad++;
        if (o_row == 0) begin
          if (hs_first < 0) hs_first = int'(o_col);
          hs_last = int'(o_col);
        end
      end
      if (!o_vsync) begin
        vs_cnt++;
        if (o_row < 14 || o_row > 15) vs_bad++;
      end
      if (o_active) begin
        act_cnt++;
        if (o_col >= 10'(H_ACT) || o_row >= 10'(V_ACT)) act_bad++;
      end
      if (o_line_start) begin
        ls_cnt++;
        if (o_col != 0) ls_bad++;
      end
      if (int'(o_col) != ec || int'(o_row) != er) seq_bad++;
      ec++;
      if (ec == H_TOT) begin ec = 0; er = (er == V_TOT - 1) ? 0 : er + 1; end
      @(negedge clk);
      k++;
    end while (!o_frame_start && k < 700);
    chk("frame_period", k, 608);
    chk("scan_sequence_errs", seq_bad, 0);
    chk("hsync_low_cycles", hs_cnt, 8 * 19);
    chk("hsync_first_col", hs_first, 20);
    chk("hsync_last_col", hs_last, 27);
    chk("hsync_outside_window", hs_bad, 0);
    chk("vsync_low_cycles", vs_cnt, 2 * 32);
    chk("vsync_outside_rows", vs_bad, 0);
    chk("active_cycles", act_cnt, 16 * 12);
    chk("active_outside_window", act_bad, 0);
    chk("line_start_count", ls_cnt, 19);
    chk("line_start_not_col0", ls_bad, 0);
    chk_out("frame1", 0, 0, 1, 1, 1, 1, 1, 1);

    // Stop request at row 4, col 0: finish the frame, then IDLE
    wait_pos("to_r4", 0, 4);
    i_enable = 1'b0;
    k = 0; pc = 0; pr = 0; fsc = 0;
    while (o_busy && k < 1000) begin
      pc = int'(o_col);
      pr = int'(o_row);
      @(negedge clk);
      k++;
      if (o_frame_start) fsc++;
    end
    chk("stop_cycles", k, 480);
    chk("stop_last_col", pc, 31);
    chk("stop_last_row", pr, 18);
    chk("stop_frame_start", fsc, 0);
    chk_out("stopped", 0, 0, 1, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_out("stopped_hold", 0, 0, 1, 1, 0, 0, 0, 0);

    // Restart, stop at row 6, re-enable at row 9: no interruption
    i_enable = 1'b1;
    @(negedge clk);
    chk_out("restart", 0, 0, 1, 1, 1, 1, 1, 1);
    wait_pos("to_r6", 0, 6);
    i_enable = 1'b0;
    k = 0; ec = 0; er = 6; bz = 0; seq_bad = 0;
    do begin
      if (!o_busy) bz++;
      if (int'(o_col) != ec || int'(o_row) != er) seq_bad++;
      if (o_row == 9 && o_col == 0) i_enable = 1'b1;
      ec++;
      if (ec == H_TOT) begin ec = 0; er = (er == V_TOT - 1) ? 0 : er + 1; end
      @(negedge clk);
      k++;
    end while (!o_frame_start && k < 1000);
    chk("resume_fs_delay", k, 416);
    chk("resume_busy_drops", bz, 0);
    chk("resume_seq_errs", seq_bad, 0);
    chk_out("resume_wrap", 0, 0, 1, 1, 1, 1, 1, 1);

`ifdef VGA_TIMING_PREFETCH_EN
    wait_pos("pf_c15", 15, 0);
    chk("pix_req_last_active", int'(o_pix_req), 0);
    wait_pos("pf_c31r0", 31, 0);
    chk("pix_req_line_end", int'(o_pix_req), 1);
    wait_pos("pf_c31r11", 31, 11);
    chk("pix_req_before_vblank", int'(o_pix_req), 0);
    wait_pos("pf_last", 31, 18);
    chk("pix_req_frame_end", int'(o_pix_req), 1);
`endif

    // Asynchronous reset mid-frame
    wait_pos("to_r8", 12, 8);
    #1 i_rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 1, 1, 0, 0, 0, 0);
`ifdef VGA_TIMING_PREFETCH_EN
    chk("async_rst.pix_req", int'(o_pix_req), 0);
`endif
    @(negedge clk);
    chk_out("rst_held", 0, 0, 1, 1, 0, 0, 0, 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk_out("post_rst", 0, 0, 1, 1, 1, 1, 1, 1);
    @(negedge clk);
    chk_out("post_rst+1", 1, 0, 1, 1, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
